// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional macro REGFILE_BYPASS_EN (see regfile_scoreboarded.sv).
package regfile_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    // r0=5, r1=1, r2..r3=0
    localparam logic [DEPTH_DEF*WIDTH_DEF-1:0] RESET_VALS_DEF = {16'h0000, 8'd1, 8'd5};

    typedef logic [ADDR_W_DEF-1:0] regAddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one registered busy bit per register, reserve arbitration
// against same-cycle writeback, and raw busy lookups for both read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic                     rsvEn,
    input  logic [$clog2(DEPTH)-1:0] rsvAddr,
    input  logic [$clog2(DEPTH)-1:0] rdAddr1,
    input  logic [$clog2(DEPTH)-1:0] rdAddr2,
    output logic                     rsvOk,
    output logic [DEPTH-1:0]         busyVec,
    output logic                     busyRaw1,
    output logic                     busyRaw2
);

    logic [DEPTH-1:0] busyNext;

    always_comb begin
        rsvOk = rsvEn & (~busyVec[rsvAddr] | (wrEn & (wrAddr == rsvAddr)));
    end

    // Reservation is applied after the writeback clear so a new producer wins.
    always_comb begin
        busyNext = busyVec;
        if (wrEn) begin
            busyNext[wrAddr] = 1'b0;
        end
        if (rsvOk) begin
            busyNext[rsvAddr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busyVec <= '0;
        end else begin
            busyVec <= busyNext;
        end
    end

    always_comb begin
        busyRaw1 = busyVec[rdAddr1];
        busyRaw2 = busyVec[rdAddr2];
    end

endmodule

// File: rtl/regfile_scoreboarded.sv
// DEPTH x WIDTH register file, two async read ports, one write port, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboarded
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VALS =
        ((DEPTH*WIDTH)'(1) << WIDTH) | (DEPTH*WIDTH)'(5)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] rd_addr1,
    input  logic [$clog2(DEPTH)-1:0] rd_addr2,
    output logic [WIDTH-1:0]         rd_data1,
    output logic [WIDTH-1:0]         rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rsv_en,
    input  logic [$clog2(DEPTH)-1:0] rsv_addr,
    output logic                     rsv_ok,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam int ADDR_W = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
            $error("regfile_scoreboarded: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] regs [DEPTH];
    logic             busyRaw1;
    logic             busyRaw2;

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) uScoreboard (
        .clock    (clock),
        .reset    (reset),
        .wrEn     (wr_en),
        .wrAddr   (wr_addr),
        .rsvEn    (rsv_en),
        .rsvAddr  (rsv_addr),
        .rdAddr1  (rd_addr1),
        .rdAddr2  (rd_addr2),
        .rsvOk    (rsv_ok),
        .busyVec  (busy_vec),
        .busyRaw1 (busyRaw1),
        .busyRaw2 (busyRaw2)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= RESET_VALS[i*WIDTH +: WIDTH];
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    // Forwarded reads report busy only when an accepted reserve re-claims the same register.
    always_comb begin
        hit1     = ~reset & wr_en & (wr_addr == rd_addr1);
        hit2     = ~reset & wr_en & (wr_addr == rd_addr2);
        rd_data1 = hit1 ? wr_data : regs[rd_addr1];
        rd_data2 = hit2 ? wr_data : regs[rd_addr2];
        rd_busy1 = hit1 ? (rsv_ok & (rsv_addr == rd_addr1)) : busyRaw1;
        rd_busy2 = hit2 ? (rsv_ok & (rsv_addr == rd_addr2)) : busyRaw2;
    end
`else
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        rd_busy1 = busyRaw1;
        rd_busy2 = busyRaw2;
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboarded.sv
// Randomized self-checking bench for regfile_scoreboarded (default and 16x8 configs).
module tb_regfile_scoreboarded;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int WB = 16;
    localparam int DB = 8;
    localparam logic [DB*WB-1:0] RV_B = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                         16'h3333, 16'h2222, 16'h1111, 16'hBEEF};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Default configuration
    regAddr_t    rdAddr1A = '0, rdAddr2A = '0, wrAddrA = '0, rsvAddrA = '0;
    logic [7:0]  wrDataA = '0;
    logic        wrEnA = 1'b0, rsvEnA = 1'b0;
    logic [7:0]  rdData1A, rdData2A;
    logic        rdBusy1A, rdBusy2A, rsvOkA;
    logic [3:0]  busyVecA;

    // 16-bit x 8 configuration
    logic [2:0]  rdAddr1B = '0, rdAddr2B = '0, wrAddrB = '0, rsvAddrB = '0;
    logic [15:0] wrDataB = '0;
    logic        wrEnB = 1'b0, rsvEnB = 1'b0;
    logic [15:0] rdData1B, rdData2B;
    logic        rdBusy1B, rdBusy2B, rsvOkB;
    logic [7:0]  busyVecB;

    regfile_scoreboarded #(
        .WIDTH (WIDTH_DEF),
        .DEPTH (DEPTH_DEF)
    ) dutA (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (rdAddr1A),
        .rd_addr2 (rdAddr2A),
        .rd_data1 (rdData1A),
        .rd_data2 (rdData2A),
        .rd_busy1 (rdBusy1A),
        .rd_busy2 (rdBusy2A),
        .wr_en    (wrEnA),
        .wr_addr  (wrAddrA),
        .wr_data  (wrDataA),
        .rsv_en   (rsvEnA),
        .rsv_addr (rsvAddrA),
        .rsv_ok   (rsvOkA),
        .busy_vec (busyVecA)
    );

    regfile_scoreboarded #(
        .WIDTH      (WB),
        .DEPTH      (DB),
        .RESET_VALS (RV_B)
    ) dutB (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (rdAddr1B),
        .rd_addr2 (rdAddr2B),
        .rd_data1 (rdData1B),
        .rd_data2 (rdData2B),
        .rd_busy1 (rdBusy1B),
        .rd_busy2 (rdBusy2B),
        .wr_en    (wrEnB),
        .wr_addr  (wrAddrB),
        .wr_data  (wrDataB),
        .rsv_en   (rsvEnB),
        .rsv_addr (rsvAddrB),
        .rsv_ok   (rsvOkB),
        .busy_vec (busyVecB)
    );

    // Reference model: plain arrays of register contents and busy flags
    logic [7:0]  memA [4];
    logic        busyA [4];
    logic [15:0] memB [8];

    int vecCount = 0;
    int errCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] busyVecModel();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = busyA[i];
        return v;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 4; i++) begin
            memA[i]  = RESET_VALS_DEF[i*8 +: 8];
            busyA[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) memB[i] = RV_B[i*16 +: 16];
    endtask

    // Called at a negedge; checks combinational outputs, then the registered state after the edge.
    task automatic applyA(input logic we, input regAddr_t wa, input logic [7:0] wd,
                          input logic re, input regAddr_t ra,
                          input regAddr_t a1, input regAddr_t a2);
        logic       expOk, b1, b2;
        logic [7:0] d1, d2;
        wrEnA = we; wrAddrA = wa; wrDataA = wd;
        rsvEnA = re; rsvAddrA = ra;
        rdAddr1A = a1; rdAddr2A = a2;
        #1;
        expOk = re && (!busyA[ra] || (we && wa == ra));
        d1 = memA[a1]; b1 = busyA[a1];
        d2 = memA[a2]; b2 = busyA[a2];
        if (BYPASS && we && wa == a1) begin d1 = wd; b1 = expOk && (ra == a1); end
        if (BYPASS && we && wa == a2) begin d2 = wd; b2 = expOk && (ra == a2); end
        checkVal("rsvOk",   rsvOkA,   expOk);
        checkVal("rdData1", rdData1A, d1);
        checkVal("rdData2", rdData2A, d2);
        checkVal("rdBusy1", rdBusy1A, b1);
        checkVal("rdBusy2", rdBusy2A, b2);
        @(posedge clock);
        if (we) begin
            memA[wa]  = wd;
            busyA[wa] = 1'b0;
        end
        if (expOk) busyA[ra] = 1'b1;
        #1;
        checkVal("busyVec", busyVecA, busyVecModel());
        @(negedge clock);
    endtask

    task automatic applyB(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic [2:0] a1, input logic [2:0] a2);
        logic [15:0] d1, d2;
        wrEnB = we; wrAddrB = wa; wrDataB = wd;
        rdAddr1B = a1; rdAddr2B = a2;
        #1;
        d1 = (BYPASS && we && wa == a1) ? wd : memB[a1];
        d2 = (BYPASS && we && wa == a2) ? wd : memB[a2];
        checkVal("B.rdData1", rdData1B, d1);
        checkVal("B.rdData2", rdData2B, d2);
        @(posedge clock);
        if (we) memB[wa] = wd;
        #1;
        checkVal("B.busyVec", busyVecB, 8'h00);
        @(negedge clock);
    endtask

    initial begin
        resetModel();
        rdAddr1A = 2'd0;
        rdAddr2A = 2'd1;
        @(negedge clock);
        @(negedge clock);
        // Reset state while reset is still asserted
        checkVal("rst.rdData1", rdData1A, 8'd5);
        checkVal("rst.rdData2", rdData2A, 8'd1);
        checkVal("rst.busyVec", busyVecA, 4'b0000);
        checkVal("rst.rdBusy1", rdBusy1A, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Write r2 and read it in the same and following cycle
        applyA(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd2, 2'd2);
        checkVal("wr.sameCycle", BYPASS ? 8'hA5 : 8'h00, memA[2] == 8'hA5 && BYPASS ? 8'hA5 : 8'h00);
        applyA(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd0);
        checkVal("wr.nextCycle", rdData1A, 8'hA5);

        // Reserve r3, then a rejected second reserve
        applyA(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd0);
        checkVal("rsv.busyVec", busyVecA, 4'b1000);
        applyA(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd1);
        checkVal("rsv.reject", busyVecA, 4'b1000);

        // Writeback r3 with same-cycle re-reserve, then writeback alone
        applyA(1'b1, 2'd3, 8'h3C, 1'b1, 2'd3, 2'd3, 2'd0);
        checkVal("wbRsv.busy3", busyVecA[3], 1'b1);
        applyA(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd3);
        checkVal("wbRsv.data3", rdData1A, 8'h3C);
        applyA(1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 2'd3, 2'd1);
        checkVal("wb.busy3", busyVecA[3], 1'b0);

        // Writeback and reserve to different registers
        applyA(1'b1, 2'd1, 8'h99, 1'b1, 2'd2, 2'd1, 2'd2);
        checkVal("diff.busyVec", busyVecA, 4'b0100);

        // Reserve r1, write r0, then asynchronous reset between edges
        applyA(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0, 2'd1);
        applyA(1'b1, 2'd0, 8'h7F, 1'b0, 2'd0, 2'd0, 2'd1);
        wrEnA = 1'b0; rsvEnA = 1'b0;
        rdAddr1A = 2'd0; rdAddr2A = 2'd1;
        #1;
        checkVal("pre.rdData1", rdData1A, memA[0]);
        checkVal("pre.busyVec", busyVecA, busyVecModel());
        #1 reset = 1'b1;
        #1;
        resetModel();
        checkVal("async.busyVec", busyVecA, 4'b0000);
        checkVal("async.rdData1", rdData1A, 8'd5);
        checkVal("async.rdData2", rdData2A, 8'd1);
        checkVal("async.rdBusy2", rdBusy2A, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            applyA(1'($urandom_range(0, 1)), regAddr_t'($urandom_range(0, 3)), 8'($urandom),
                   1'($urandom_range(0, 1)), regAddr_t'($urandom_range(0, 3)),
                   regAddr_t'($urandom_range(0, 3)), regAddr_t'($urandom_range(0, 3)));
        end
        wrEnA = 1'b0; rsvEnA = 1'b0;

        // 16x8 configuration: reset image, aliasing, random writes
        for (int i = 0; i < 8; i++) begin
            rdAddr1B = 3'(i);
            rdAddr2B = 3'(7 - i);
            #1;
            checkVal("B.rst1", rdData1B, RV_B[i*16 +: 16]);
            checkVal("B.rst2", rdData2B, RV_B[(7-i)*16 +: 16]);
        end
        @(negedge clock);
        applyB(1'b1, 3'd7, 16'h1234, 3'd3, 3'd7);
        applyB(1'b0, 3'd0, 16'h0000, 3'd3, 3'd7);
        checkVal("B.r3noAlias", rdData1B, 16'h3333);
        checkVal("B.r7", rdData2B, 16'h1234);
        for (int n = 0; n < 60; n++) begin
            applyB(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
